// File: rtl/mdu_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer.
// Latency: n/a (constants, state type and decode helpers only).
// Backpressure: n/a.
package mdu_pkg;

  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [5:0] FUNC_MFHI  = 6'b010000;
  localparam logic [5:0] FUNC_MTHI  = 6'b010001;
  localparam logic [5:0] FUNC_MFLO  = 6'b010010;
  localparam logic [5:0] FUNC_MTLO  = 6'b010011;
  localparam logic [5:0] FUNC_MULT  = 6'b011000;
  localparam logic [5:0] FUNC_MULTU = 6'b011001;
  localparam logic [5:0] FUNC_DIV   = 6'b011010;
  localparam logic [5:0] FUNC_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  // HI/LO group: move ops share func[5:2] = 0100, mult/div ops share 0110.
  function automatic logic is_mdu_group(input logic [1:0] alu_op, input logic [5:0] func);
    return (alu_op == ALUOP_RTYPE) &&
           ((func[5:2] == 4'b0100) || (func[5:2] == 4'b0110));
  endfunction

  function automatic logic is_muldiv(input logic [5:0] func);
    return func[5:2] == 4'b0110;
  endfunction

endpackage

// File: rtl/mdu_iter.sv
// Iterative datapath: shift-add multiply / restoring divide on operand magnitudes.
// Latency: one iteration per step strobe; sign-fixed result is combinational from state.
// Backpressure: none; sequencing fully owned by mdu_seq via start/step.
//
// Ports: start latches operands and sign flags; step performs one iteration;
// res_hi/res_lo present the sign-corrected product or remainder/quotient.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step,
  input  logic             is_div,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  // acc: upper product half / partial remainder.
  // lo_r: multiplier being consumed / dividend shifting out, quotient shifting in.
  // opb: multiplicand / divisor magnitude.
  logic [WIDTH-1:0] acc, lo_r, opb;
  logic             div_op, neg_q, neg_r, div0;

  logic             sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum, rem_sh, rem_diff;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo, rem;

  always_comb begin
    sa    = is_signed & src_a[WIDTH-1];
    sb    = is_signed & src_b[WIDTH-1];
    // MIN negates to itself, which read as unsigned is its correct magnitude.
    mag_a = sa ? -src_a : src_a;
    mag_b = sb ? -src_b : src_b;
  end

  always_comb begin
    mul_sum  = {1'b0, acc} + (lo_r[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
    rem_sh   = {acc, lo_r[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, opb};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      lo_r   <= '0;
      opb    <= '0;
      div_op <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
    end else if (start) begin
      acc    <= '0;
      lo_r   <= is_div ? mag_a : mag_b;
      opb    <= is_div ? mag_b : mag_a;
      div_op <= is_div;
      neg_q  <= sa ^ sb;
      neg_r  <= sa;
      div0   <= (src_b == '0);
    end else if (step) begin
      if (div_op) begin
        // Restoring step: keep the subtraction only if it did not go negative.
        if (!rem_diff[WIDTH]) begin
          acc  <= rem_diff[WIDTH-1:0];
          lo_r <= {lo_r[WIDTH-2:0], 1'b1};
        end else begin
          acc  <= rem_sh[WIDTH-1:0];
          lo_r <= {lo_r[WIDTH-2:0], 1'b0};
        end
      end else begin
        acc  <= mul_sum[WIDTH:1];
        lo_r <= {mul_sum[0], lo_r[WIDTH-1:1]};
      end
    end
  end

  // With a zero divisor every trial subtract succeeds, so the remainder ends as
  // |a| and re-signs to the original dividend; only the quotient is forced.
  always_comb begin
    prod     = {acc, lo_r};
    prod_fix = neg_q ? -prod : prod;
    quo      = div0 ? {WIDTH{1'b1}} : (neg_q ? -lo_r : lo_r);
    rem      = neg_r ? -acc : acc;
    res_hi   = div_op ? rem : prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = div_op ? quo : prod_fix[WIDTH-1:0];
  end

endmodule

// File: rtl/mdu_seq.sv
// HI/LO multiply/divide sequencer for the EX stage; owns HI/LO and the mf/mt moves.
// Latency: mult/div busy WIDTH+1 cycles, done pulses the cycle after; mfhi/mflo data 1 cycle.
// Backpressure: combinational stall on any group instruction while busy; flush kills the op.
//
// Ports: alu_op/func/issue/flush/src_a/src_b from EX; stall/busy/done status;
// hi/lo architectural registers; rd_data/rd_valid registered move-from result.
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       func,
  input  logic             issue,
  input  logic             flush,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             grp, accept, start, step;
  logic [WIDTH-1:0] res_hi, res_lo;

  always_comb begin
    grp    = is_mdu_group(alu_op, func);
    busy   = (state != IDLE);
    accept = issue && grp && (state == IDLE) && !flush;
    stall  = issue && grp && busy && !flush;
    start  = accept && is_muldiv(func);
    step   = (state == RUN) && !flush;
  end

  mdu_iter #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .step      (step),
    .is_div    (func[1]),
    .is_signed (~func[0]),
    .src_a     (src_a),
    .src_b     (src_b),
    .res_hi    (res_hi),
    .res_lo    (res_lo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      done     <= 1'b0;
    end else begin
      done     <= 1'b0;
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            case (func)
              FUNC_MFHI: begin
                rd_data  <= hi;
                rd_valid <= 1'b1;
              end
              FUNC_MFLO: begin
                rd_data  <= lo;
                rd_valid <= 1'b1;
              end
              FUNC_MTHI: hi <= src_a;
              FUNC_MTLO: lo <= src_a;
              default: begin
                state <= RUN;
                cnt   <= '0;
              end
            endcase
          end
        end
        RUN: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_LAST) begin
              state <= FIX;
            end
          end
        end
        FIX: begin
          state <= IDLE;
          if (!flush) begin
            hi   <= res_hi;
            lo   <= res_lo;
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_seq.sv
module tb_mdu_seq;
  import mdu_pkg::*;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    alu_op;
  logic [5:0]    func;
  logic          issue, flush;
  logic [W-1:0]  src_a, src_b;
  logic          stall, busy, done, rd_valid;
  logic [W-1:0]  hi, lo, rd_data;

  logic [1:0]    b_alu_op;
  logic [5:0]    b_func;
  logic          b_issue, b_flush;
  logic [7:0]    b_src_a, b_src_b;
  logic          b_stall, b_busy, b_done, b_rd_valid;
  logic [7:0]    b_hi, b_lo, b_rd_data;

  always #5 clk = ~clk;

  mdu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .alu_op(alu_op), .func(func), .issue(issue),
    .flush(flush), .src_a(src_a), .src_b(src_b), .stall(stall), .busy(busy),
    .done(done), .hi(hi), .lo(lo), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  mdu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .alu_op(b_alu_op), .func(b_func), .issue(b_issue),
    .flush(b_flush), .src_a(b_src_a), .src_b(b_src_b), .stall(b_stall), .busy(b_busy),
    .done(b_done), .hi(b_hi), .lo(b_lo), .rd_data(b_rd_data), .rd_valid(b_rd_valid)
  );

  logic [63:0] exp_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] m_hi, m_lo;
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic signed [63:0] pa, pb;
    sa = a; sb = b; pa = sa; pb = sb;
    case (f)
      FUNC_MULT:  model = pa * pb;
      FUNC_MULTU: model = {32'b0, a} * {32'b0, b};
      FUNC_DIV:
        if (b == 32'd0)                                  model = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = {32'h0, 32'h8000_0000};
        else                                             model = {sa % sb, sa / sb};
      FUNC_DIVU:
        if (b == 32'd0) model = {a, 32'hFFFF_FFFF};
        else            model = {a % b, a / b};
      default: model = '0;
    endcase
  endfunction

  // Scoreboard side: every done / rd_valid pops the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (done) begin
        if (exp_q.size() == 0) check("done_unexpected", 1, 0);
        else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          check("sb_hi", hi, e[63:32]);
          check("sb_lo", lo, e[31:0]);
        end
      end
      if (rd_valid) begin
        if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
        else check("sb_rd", rd_data, rd_q.pop_front());
      end
    end
  end

  task automatic issue_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input bit upd);
    logic [63:0] e;
    @(posedge clk); #1;
    alu_op = ALUOP_RTYPE; func = f; src_a = a; src_b = b; issue = 1'b1;
    case (f)
      FUNC_MFHI: rd_q.push_back(m_hi);
      FUNC_MFLO: rd_q.push_back(m_lo);
      FUNC_MTHI: m_hi = a;
      FUNC_MTLO: m_lo = a;
      default: if (upd) begin
        e = model(f, a, b);
        exp_q.push_back(e);
        m_hi = e[63:32];
        m_lo = e[31:0];
      end
    endcase
    @(posedge clk); #1;
    issue = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_busy);
    int n = 0;
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (busy) n++;
      if (done) seen = 1;
    end
    check({tag, "_done"}, seen, 1);
    check({tag, "_busy_cycles"}, n, exp_busy);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; alu_op = 2'b00; func = 6'd0; issue = 1'b0; flush = 1'b0;
    src_a = '0; src_b = '0;
    b_alu_op = 2'b00; b_func = 6'd0; b_issue = 1'b0; b_flush = 1'b0; b_src_a = '0; b_src_b = '0;
    m_hi = '0; m_lo = '0;
    #1;
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rdv", rd_valid, 0);
    check("rst_rd", rd_data, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed mult/div cases.
    issue_op(FUNC_MULT, 32'hFFFF_FFFE, 32'd3, 1);
    wait_done("mult", W + 1);
    check("mult_hi_lit", hi, 32'hFFFF_FFFF);
    check("mult_lo_lit", lo, 32'hFFFF_FFFA);
    issue_op(FUNC_MULTU, 32'hFFFF_FFFE, 32'd3, 1);
    wait_done("multu", W + 1);
    check("multu_hi_lit", hi, 32'h0000_0002);
    issue_op(FUNC_DIV, -32'sd7, 32'd2, 1);
    wait_done("div", W + 1);
    check("div_lo_lit", lo, 32'hFFFF_FFFD);
    check("div_hi_lit", hi, 32'hFFFF_FFFF);
    issue_op(FUNC_DIVU, 32'd100, 32'd7, 1);
    wait_done("divu", W + 1);
    issue_op(FUNC_DIVU, 32'h1234_5678, 32'd0, 1);
    wait_done("divu0", W + 1);
    check("divu0_hi_lit", hi, 32'h1234_5678);
    issue_op(FUNC_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    wait_done("div_ovf", W + 1);
    issue_op(FUNC_DIV, -32'sd5, 32'd0, 1);
    wait_done("div0_neg", W + 1);
    issue_op(FUNC_MFHI, 0, 0, 1);
    issue_op(FUNC_MFLO, 0, 0, 1);

    // Random operand mix.
    for (int i = 0; i < 6; i++) begin
      logic [5:0]  f;
      logic [31:0] a, b;
      f = FUNC_MULT + 6'($urandom_range(0, 3));
      a = $urandom;
      b = (i % 2 == 1) ? 32'($urandom_range(0, 20)) : $urandom;
      if (i == 4) b = -32'sd3;
      issue_op(f, a, b, 1);
      wait_done("rand", W + 1);
    end

    // mfhi arriving while busy must stall until the done cycle.
    begin
      int n_st = 0;
      bit seen = 0;
      issue_op(FUNC_MULT, 32'd7, -32'sd9, 1);
      repeat (4) @(posedge clk);
      #1;
      alu_op = ALUOP_RTYPE; func = FUNC_MFHI; issue = 1'b1;
      for (int i = 0; i < 200 && !seen; i++) begin
        @(negedge clk);
        if (done) begin
          seen = 1;
          check("stall_in_done_cycle", stall, 0);
        end else if (stall) n_st++;
      end
      check("stall_seen_done", seen, 1);
      check("stall_cycles", n_st, W - 3);
      rd_q.push_back(m_hi);
      @(posedge clk); #1;
      issue = 1'b0;
      @(negedge clk);
      check("stall_rd_valid", rd_valid, 1);
    end

    // Non-group and wrong-alu_op instructions never stall, even while busy.
    issue_op(FUNC_MULTU, 32'd1000, 32'd1000, 1);
    alu_op = 2'b00; func = FUNC_MULT; issue = 1'b1;
    @(negedge clk);
    check("ign_aluop_stall", stall, 0);
    #1 alu_op = ALUOP_RTYPE; func = 6'b100000;
    @(negedge clk);
    check("ign_func_stall", stall, 0);
    #1 issue = 1'b0;
    wait_done("multu_ign", W - 1);
    @(posedge clk); #1;
    alu_op = 2'b00; func = FUNC_MULT; issue = 1'b1;
    @(negedge clk);
    check("ign_idle_stall", stall, 0);
    @(posedge clk); #1 issue = 1'b0;
    @(negedge clk);
    check("ign_idle_busy", busy, 0);

    // Flush kills a divide mid-run; flush alongside issue drops the instruction.
    begin
      int nd = 0;
      issue_op(FUNC_MTHI, 32'hA5A5_A5A5, 0, 1);
      issue_op(FUNC_DIV, 32'd100, 32'd7, 0);
      repeat (9) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1 flush = 1'b0;
      @(negedge clk);
      check("flush_busy", busy, 0);
      for (int i = 0; i < W + 5; i++) begin
        @(negedge clk);
        if (done) nd++;
      end
      check("flush_no_done", nd, 0);
      check("flush_hi", hi, 32'hA5A5_A5A5);
      @(posedge clk); #1;
      alu_op = ALUOP_RTYPE; func = FUNC_MTHI; src_a = 32'hDEAD_BEEF; issue = 1'b1; flush = 1'b1;
      @(posedge clk); #1 issue = 1'b0; flush = 1'b0;
      check("flush_issue_hi", hi, 32'hA5A5_A5A5);
      issue_op(FUNC_MFLO, 0, 0, 1);
    end

    // Asynchronous reset in the middle of a run.
    issue_op(FUNC_MULT, 32'd5, 32'd6, 1);
    repeat (7) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_hi", hi, 0);
    check("arst_lo", lo, 0);
    check("arst_busy", busy, 0);
    check("arst_rd", rd_data, 0);
    exp_q.delete(); rd_q.delete();
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("arst_busy_after", busy, 0);
    check("arst_done_after", done, 0);
    issue_op(FUNC_MFHI, 0, 0, 1);

    // 8-bit build.
    begin
      int n = 0;
      bit seen = 0;
      @(posedge clk); #1;
      b_alu_op = ALUOP_RTYPE; b_func = FUNC_MULTU; b_src_a = 8'hFF; b_src_b = 8'hFF; b_issue = 1'b1;
      @(posedge clk); #1 b_issue = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
        @(negedge clk);
        if (b_busy) n++;
        if (b_done) seen = 1;
      end
      check("w8_done", seen, 1);
      check("w8_busy_cycles", n, 9);
      check("w8_hi", b_hi, 8'hFE);
      check("w8_lo", b_lo, 8'h01);
    end

    repeat (3) @(posedge clk);
    check("sb_exp_left", exp_q.size(), 0);
    check("sb_rd_left", rd_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Parametrised multiply/divide sequencer for the EX stage; sits beside the main ALU.
- Decodes R-type FuncCode (alu_op = 2'b10) for the HI/LO instruction group: mult, multu, div, divu, mfhi, mflo, mthi, mtlo.
- Runs iterative shift-add multiply and restoring divide over WIDTH cycles.
- Owns the HI/LO registers and issues stall back to the pipeline while busy.

Parameters:
- WIDTH, 32, operand/HI/LO width; even, >= 4.
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- alu_op  input  2  main-decoder ALU op; block responds only to 2'b10.
- func  input  6  instruction FuncCode.
- issue  input  1  EX stage holds a valid instruction this cycle.
- flush  input  1  kill in-flight op (exception/branch squash).
- src_a  input  WIDTH  rs value (dividend / multiplicand / mthi-mtlo data).
- src_b  input  WIDTH  rt value (divisor / multiplier).
- stall  output  1  combinational: issue && mdu-group func && busy && !flush.
- busy  output  1  sequencer in RUN or FIX.
- done  output  1  one-cycle pulse: mult/div result written to HI/LO.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- rd_data  output  WIDTH  registered mfhi/mflo result.
- rd_valid  output  1  one-cycle pulse qualifying rd_data.

Behaviour:
- Func codes: mfhi 010000, mthi 010001, mflo 010010, mtlo 010011, mult 011000, multu 011001, div 011010, divu 011011. Any other func, or alu_op != 2'b10: ignored, no stall.
- Reset: state IDLE; hi, lo, rd_data = 0; busy, done, rd_valid = 0; counter = 0.
- Accept: issue && group func && state IDLE && !flush, sampled at rising edge.
- mthi/mtlo: hi/lo <= src_a at the accept edge.
- mfhi/mflo: rd_data <= hi/lo, rd_valid = 1 for the following cycle.
- States:
  - IDLE: on accepted mult/div, latch |src_a|, |src_b| (signed ops) or raw operands (unsigned), plus result-sign flags; go to RUN; counter = 0.
  - RUN: one iteration per cycle; counter++.
    - Multiply: shift-add, product held 2*WIDTH.
    - Divide: restoring, one quotient bit per cycle.
    - Leave for FIX when counter == WIDTH-1, i.e. WIDTH cycles in RUN.
  - FIX: apply two's-complement negation.
    - Product: negated if sign(a) XOR sign(b).
    - Quotient: negated if signs differ.
    - Remainder: takes the sign of the dividend.
    - Write {hi,lo} (mult) or hi = remainder, lo = quotient (div).
    - Go to IDLE; done = 1 in the next cycle.
- Latency: accept at edge E0; busy high for cycles E0..E(WIDTH+1); HI/LO valid and done high after edge E(WIDTH+1).
  - mfhi issued in the done cycle is accepted and returns the new value.
- Divide by zero (div and divu): lo = {WIDTH{1'b1}}, hi = src_a as issued; same latency, no exception.
- Signed overflow (MIN / -1): lo = MIN, hi = 0.
- MIN operand magnitude is handled as an unsigned WIDTH-bit value; no extra bit is needed.
- Any group instruction arriving while busy: stall = 1, not accepted, HI/LO untouched.
- Flush:
  - Synchronous; overrides issue.
  - In RUN/FIX: state -> IDLE; busy falls at the next edge; HI/LO unchanged; no done.
  - Flush together with issue: instruction dropped.
  - Pending rd_valid still fires.
- Asynchronous reset mid-operation: immediate return to the reset values above.

Decomposition:
- Package mdu_pkg:
  - FUNC_MFHI .. FUNC_DIVU constants.
  - ALUOP_RTYPE = 2'b10.
  - State enum {IDLE, RUN, FIX}.
- Sub-module mdu_iter: datapath only (accumulator/remainder registers, one-step add/subtract-shift, final negate) under start/step/fix strobes from the FSM in mdu_seq.

Test Plan:
- mult: src_a = 32'hFFFF_FFFE (-2), src_b = 3 -> done after 33 busy cycles; hi = 32'hFFFF_FFFF, lo = 32'hFFFF_FFFA. Then multu with the same operands -> hi = 32'h0000_0002, lo = 32'hFFFF_FFFA.
- div: src_a = -7, src_b = 2 -> lo = 32'hFFFF_FFFD (-3), hi = 32'hFFFF_FFFF (-1). Then divu 100 / 7 -> lo = 14, hi = 2.
- divu by zero: src_a = 32'h1234_5678, src_b = 0 -> lo = 32'hFFFF_FFFF, hi = 32'h1234_5678. Also div 32'h8000_0000 / -1 -> lo = 32'h8000_0000, hi = 0.
- mfhi issued 5 cycles after a mult accept -> stall high until the done cycle; accepted in the done cycle; rd_valid with the new hi the next cycle.
- flush asserted on cycle 10 of a div after mthi 32'hA5A5_A5A5 -> busy falls, no done, hi stays 32'hA5A5_A5A5. Then mflo returns the prior lo.
- rst_n pulsed low mid-RUN -> all outputs 0 asynchronously. Then alu_op = 2'b00 with func = 011000 -> ignored, stall = 0. WIDTH = 8 build: multu 8'hFF * 8'hFF -> hi = 8'hFE, lo = 8'h01 after 9 busy cycles.
